pc_fetch_ctrl: RTL and testbench

Program-counter register and instruction-fetch sequencer, directly downstream of the next-PC selector (PC-jumper stage). Holds the architectural PC and presents PC+4 back to the selector as its base address. Accepts the selector's next-PC value and runs a request/acknowledge fetch against instruction memory. Hands the fetched word to decode with a valid flag, and honours stall and halt from the control unit.

---
 rtl/pc_fetch_ctrl_if.sv | 35 +++
 rtl/pc_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl_if
// Description : Fetch-controller bundle (selector, control unit, imem, decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if;
    logic        start;
    logic [31:0] nextPC;
    logic        stall;
    logic        halt;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] currentPC;
    logic [31:0] pcPlus4;
    logic [31:0] instruction;
    logic        instValid;
    logic        halted;
    logic        fetchError;

    modport master (
        input  start, nextPC, stall, halt, imem_ack, imem_rdata,
        output imem_req, imem_addr, currentPC, pcPlus4, instruction,
               instValid, halted, fetchError
    );

    modport slave (
        output start, nextPC, stall, halt, imem_ack, imem_rdata,
        input  imem_req, imem_addr, currentPC, pcPlus4, instruction,
               instValid, halted, fetchError
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : PC register and req/ack instruction-fetch sequencer.
//               Optional macro PC_ALIGN_CHECK_EN: misaligned nextPC -> ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16            // 2..255
) (
    input  wire logic         CLK,
    input  wire logic         Reset,
    pc_fetch_ctrl_if.master   fetch_bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [7:0] c_timeout_last = 8'(ACK_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [31:0] w_pc_aligned;

    assign w_pc_aligned = fetch_bus.nextPC & 32'hFFFF_FFFC;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_cnt   <= 8'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (fetch_bus.start) begin
                    w_state_nxt = ST_FETCH;
                    w_cnt_nxt   = 8'h0;
                end
            end
            ST_FETCH: begin
                // An ack on the final allowed cycle still completes the fetch
                if (fetch_bus.imem_ack) begin
                    w_instr_nxt = fetch_bus.imem_rdata;
                    w_cnt_nxt   = 8'h0;
                    w_state_nxt = ST_ISSUE;
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_ISSUE: begin
                if (fetch_bus.halt) begin
                    w_state_nxt = ST_HALT;
                end else if (!fetch_bus.stall) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (fetch_bus.nextPC[1:0] != 2'b00) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_pc_nxt    = w_pc_aligned;
                        w_cnt_nxt   = 8'h0;
                        w_state_nxt = ST_FETCH;
                    end
`else
                    w_pc_nxt    = w_pc_aligned;
                    w_cnt_nxt   = 8'h0;
                    w_state_nxt = ST_FETCH;
`endif
                end
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign fetch_bus.imem_req    = (r_state == ST_FETCH);
    assign fetch_bus.imem_addr   = r_pc;
    assign fetch_bus.currentPC   = r_pc;
    assign fetch_bus.pcPlus4     = r_pc + 32'd4;
    assign fetch_bus.instruction = r_instr;
    assign fetch_bus.instValid   = (r_state == ST_ISSUE);
    assign fetch_bus.halted      = (r_state == ST_HALT);
    assign fetch_bus.fetchError  = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Scoreboard bench for pc_fetch_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam int          c_timeout  = 16;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .RESET_PC    (c_reset_pc),
        .ACK_TIMEOUT (c_timeout)
    ) u_dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .fetch_bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        prev_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Each new instruction handed to decode is matched against the scoreboard
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (bus.instValid === 1'b1 && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected", 32'(sb_q.size()), 32'd1);
                end else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    check_val("sb_instr", bus.instruction, e[63:32]);
                    check_val("sb_pc", bus.currentPC, e[31:0]);
                end
            end
            prev_valid = (bus.instValid === 1'b1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stall    = 1'b0;
        bus.halt     = 1'b0;
        bus.imem_ack = 1'b0;
        tick();
        Reset  = 1'b0;
        exp_pc = c_reset_pc;
        check_val("rst_pc", bus.currentPC, c_reset_pc);
        check_val("rst_addr", bus.imem_addr, c_reset_pc);
        check_val("rst_req", 32'(bus.imem_req), 32'd0);
        check_val("rst_instr", bus.instruction, 32'd0);
        check_val("rst_valid", 32'(bus.instValid), 32'd0);
        check_val("rst_halted", 32'(bus.halted), 32'd0);
        check_val("rst_err", 32'(bus.fetchError), 32'd0);
    endtask

    task automatic go_fetch();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val("start_req", 32'(bus.imem_req), 32'd1);
    endtask

    // Enters in FETCH; acks after 'waits' idle cycles; leaves in ISSUE
    task automatic fetch(input logic [31:0] rdata, input int waits);
        for (int i = 0; i < waits; i++) begin
            check_val("wait_req", 32'(bus.imem_req), 32'd1);
            check_val("wait_addr", bus.imem_addr, exp_pc);
            check_val("wait_valid", 32'(bus.instValid), 32'd0);
            tick();
        end
        check_val("ack_req", 32'(bus.imem_req), 32'd1);
        check_val("ack_addr", bus.imem_addr, exp_pc);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        sb_q.push_back({rdata, exp_pc});
        exp_instr = rdata;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        check_val("issue_valid", 32'(bus.instValid), 32'd1);
        check_val("issue_req", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic advance(input logic [31:0] npc);
        bus.nextPC = npc;
        tick();
        exp_pc = npc & 32'hFFFF_FFFC;
        check_val("adv_pc", bus.currentPC, exp_pc);
        check_val("adv_plus4", bus.pcPlus4, exp_pc + 32'd4);
        check_val("adv_req", 32'(bus.imem_req), 32'd1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.nextPC     = 32'h0;
        bus.stall      = 1'b0;
        bus.halt       = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        exp_pc         = c_reset_pc;
        exp_instr      = 32'h0;
        do_reset();

        // Immediate ack, then advance to 4
        go_fetch();
        check_val("t1_addr", bus.imem_addr, 32'h0);
        fetch(32'h2001_0005, 0);
        advance(32'h0000_0004);
        check_val("t1_plus4", bus.pcPlus4, 32'h0000_0008);

        // Ack delayed 5 cycles
        fetch(32'hDEAD_0001, 5);

        // Stall for 3 cycles; nextPC must be ignored meanwhile
        bus.stall  = 1'b1;
        bus.nextPC = 32'h0000_0100;
        repeat (3) begin
            tick();
            check_val("stall_valid", 32'(bus.instValid), 32'd1);
            check_val("stall_instr", bus.instruction, exp_instr);
            check_val("stall_pc", bus.currentPC, exp_pc);
        end
        bus.stall = 1'b0;
        advance(32'h0000_0040);
        fetch(32'h1234_5678, 1);

        // Halt wins over stall; start and ack cannot leave HALT
        bus.halt  = 1'b1;
        bus.stall = 1'b1;
        tick();
        bus.halt  = 1'b0;
        bus.stall = 1'b0;
        check_val("halt_halted", 32'(bus.halted), 32'd1);
        check_val("halt_valid", 32'(bus.instValid), 32'd0);
        check_val("halt_pc", bus.currentPC, exp_pc);
        bus.start    = 1'b1;
        bus.imem_ack = 1'b1;
        repeat (3) begin
            tick();
            check_val("halt_req", 32'(bus.imem_req), 32'd0);
            check_val("halt_stay", 32'(bus.halted), 32'd1);
        end
        bus.start    = 1'b0;
        bus.imem_ack = 1'b0;
        do_reset();

        // Ack timeout into ERROR
        go_fetch();
        for (int i = 0; i < c_timeout; i++) begin
            check_val("to_req", 32'(bus.imem_req), 32'd1);
            check_val("to_noerr", 32'(bus.fetchError), 32'd0);
            tick();
        end
        check_val("to_err", 32'(bus.fetchError), 32'd1);
        check_val("to_req_off", 32'(bus.imem_req), 32'd0);
        check_val("to_valid", 32'(bus.instValid), 32'd0);
        bus.start    = 1'b1;
        bus.imem_ack = 1'b1;
        tick();
        check_val("to_sticky", 32'(bus.fetchError), 32'd1);
        check_val("to_sticky_req", 32'(bus.imem_req), 32'd0);
        bus.start    = 1'b0;
        bus.imem_ack = 1'b0;
        do_reset();

        // Ack on the expiry cycle completes the fetch
        go_fetch();
        fetch(32'hCAFE_F00D, c_timeout - 1);
        check_val("edge_noerr", 32'(bus.fetchError), 32'd0);

        // Reset mid-fetch, then a late ack is ignored
        advance(32'h0000_0008);
        Reset = 1'b1;
        tick();
        Reset  = 1'b0;
        exp_pc = c_reset_pc;
        check_val("mid_req", 32'(bus.imem_req), 32'd0);
        check_val("mid_addr", bus.imem_addr, c_reset_pc);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.imem_ack = 1'b0;
        check_val("late_req", 32'(bus.imem_req), 32'd0);
        check_val("late_valid", 32'(bus.instValid), 32'd0);
        check_val("late_instr", bus.instruction, 32'd0);

        // pcPlus4 wraps
        go_fetch();
        fetch(32'h0000_0013, 0);
        advance(32'hFFFF_FFFC);
        check_val("wrap_plus4", bus.pcPlus4, 32'h0000_0000);
        fetch(32'h0000_0017, 2);

        // Misaligned nextPC
        bus.nextPC = 32'h0000_0006;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check_val("align_err", 32'(bus.fetchError), 32'd1);
        check_val("align_pc", bus.currentPC, 32'hFFFF_FFFC);
        check_val("align_req", 32'(bus.imem_req), 32'd0);
`else
        exp_pc = 32'h0000_0004;
        check_val("align_pc", bus.currentPC, 32'h0000_0004);
        check_val("align_addr", bus.imem_addr, 32'h0000_0004);
        check_val("align_noerr", 32'(bus.fetchError), 32'd0);
        fetch(32'h0000_0033, 0);
`endif

        repeat (2) tick();
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
